snake_motion: RTL
=================

SNAKE_MOTION -- requirements
Module: snake_motion

Interface
REQ-001 SHALL have parameter STEP_DIV, default 8, meaning frame ticks per snake step (range 1..255).
REQ-002 SHALL have parameter CELL, default 16, meaning segment edge and step size in pixels.
REQ-003 SHALL have port clk, input, 1, the single clock for all state.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port tick, input, 1, one-clk frame pulse; same signal as the display update strobe.
REQ-006 SHALL have port start, input, 1, level-sampled start/restart request.
REQ-007 SHALL have port dir_btn, input, 4, {up,down,left,right}, active-high, sampled every clk.
REQ-008 SHALL have port food, input, 40, food record {w,h,x,y}, 10 bits each.
REQ-009 SHALL have port head, output, 40, head record {w[39:30],h[29:20],x[19:10],y[9:0]}.
REQ-010 SHALL have port body, output, 200, five records; segment 0 (nearest the head) at [199:160], segment 4 at [39:0].
REQ-011 SHALL have port grow, output, 1, one-clk pulse when food is eaten.
REQ-012 SHALL have port endgame, output, 1, high while the game is over.

Function
REQ-013 SHALL use a y axis that increases upward; the play area is x 16..607 and y 16..447.
REQ-014 SHALL implement FSM states IDLE, RUN and DEAD.
REQ-015 SHALL transition IDLE->RUN on start=1, RUN->DEAD on a collision, and DEAD->RUN on start=1 with full reinitialisation.
REQ-016 SHALL latch a pending direction from dir_btn with priority up>down>left>right.
REQ-017 SHALL ignore a request for the exact reverse of the current direction.
REQ-018 SHALL count tick pulses only in RUN; each time the count reaches STEP_DIV-1 it wraps to 0 and performs one step.
REQ-019 SHALL, on a step, adopt the pending direction and compute the new head as old head ±CELL on the x or y axis.
REQ-020 SHALL, on a step, shift records: segment0<-old head and segment i<-segment i-1.
REQ-021 SHALL force every record at index >= len to all-zero, so that w=h=0 makes it invisible.
REQ-022 SHALL treat new head x==food x and y==food y as eating: len increments saturating at 5, and grow pulses for 1 clk in the step cycle+1.
REQ-023 SHALL treat a fence hit as new head x<16, x>592, y<16 or y>432.
REQ-024 SHALL treat a self hit as the new head equal to any active pre-move segment, excluding the tail segment unless the snake grows this step.
REQ-025 SHALL, on a fence or self hit, suppress the step so that head and body hold, set endgame=1 and enter DEAD.
REQ-026 SHALL register head, body, grow and endgame, with outputs updating exactly 1 clk after the tick that completes a step.
REQ-027 SHALL give collision priority over eating when both occur in the same step.
REQ-028 SHALL ignore tick and dir_btn while in IDLE and DEAD.
REQ-029 SHALL treat a start that is still high in RUN as having no effect.
REQ-030 SHALL perform all arithmetic in 10 bits unsigned; the fence check precedes any use of the new head, so no wrap is ever committed.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, enter IDLE, regardless of current state or any step in progress.
REQ-032 SHALL reset head to {16,16,304,224}.
REQ-033 SHALL reset segment0 to {16,16,288,224}, segment1 to {16,16,272,224}, and segments 2..4 to 0.
REQ-034 SHALL reset len to 2, direction and pending direction to right, and the tick count to 0.
REQ-035 SHALL hold grow=0 and endgame=0 during and after reset.
REQ-036 SHALL have the restart path (DEAD->RUN) load identical values to reset.

Structure
REQ-037 SHALL place in shared package snake_pkg: CELL, play-area bounds, field offsets of the 40-bit record, direction encoding, and the FSM state type.
REQ-038 SHALL have the display-side consumer import the same record offsets from snake_pkg.
REQ-039 SHALL contain one sub-module, snake_collide, a combinational block taking new head, body, len and grow flag and returning fence_hit and self_hit.

Verification
REQ-040 SHALL verify reset then start=1, with STEP_DIV=2 and 2 ticks -> head x=320 y=224, segment0 x=304, segment1 x=288, endgame=0.
REQ-041 SHALL verify that moving right, pressing left then right and up together -> left ignored, up taken, and the next step gives head y=240.
REQ-042 SHALL verify food at (320,224), one step -> grow high 1 clk, len=3, segment2 x=272 now nonzero.
REQ-043 SHALL verify head at x=592 moving right, one step -> endgame=1, state DEAD, and head x stays 592 on further ticks.
REQ-044 SHALL verify a len=5 snake steered up/left/down into itself -> self hit, endgame=1; then start=1 -> reset values restored, endgame=0.
REQ-045 SHALL verify rst asserted on the same clk as a step-completing tick -> outputs equal reset values next clk, grow=0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: record layout, play-area bounds,
// direction encoding and the motion FSM state type.
package snake_pkg;

  localparam int CELL  = 16;
  localparam int FLD_W = 10;
  localparam int REC_W = 40;
  localparam int NSEG  = 5;

  // Field offsets inside a 40-bit {w,h,x,y} record.
  localparam int W_LSB = 30;
  localparam int H_LSB = 20;
  localparam int X_LSB = 10;
  localparam int Y_LSB = 0;

  localparam logic [FLD_W-1:0] AREA_X_LO = 10'd16;
  localparam logic [FLD_W-1:0] AREA_X_HI = 10'd607;
  localparam logic [FLD_W-1:0] AREA_Y_LO = 10'd16;
  localparam logic [FLD_W-1:0] AREA_Y_HI = 10'd447;
  // Largest legal head origin: the whole cell must stay inside the area.
  localparam logic [FLD_W-1:0] HEAD_X_MAX = 10'(int'(AREA_X_HI) + 1 - CELL);
  localparam logic [FLD_W-1:0] HEAD_Y_MAX = 10'(int'(AREA_Y_HI) + 1 - CELL);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  function automatic logic [FLD_W-1:0] rec_x(input logic [REC_W-1:0] r);
    return r[X_LSB +: FLD_W];
  endfunction

  function automatic logic [FLD_W-1:0] rec_y(input logic [REC_W-1:0] r);
    return r[Y_LSB +: FLD_W];
  endfunction

  function automatic dir_t dir_reverse(input dir_t d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

  // Button bit for a direction within dir_btn = {up,down,left,right}.
  function automatic logic [3:0] dir_onehot(input dir_t d);
    return 4'b1000 >> d;
  endfunction

endpackage

// File: rtl/snake_collide.sv
// Combinational collision check of a candidate head against the fence and
// the pre-move body.
module snake_collide
  import snake_pkg::*;
(
  input  logic [REC_W-1:0]      new_head,
  input  logic [NSEG*REC_W-1:0] body,
  input  logic [2:0]            len,
  input  logic                  grow,
  output logic                  fence_hit,
  output logic                  self_hit
);

  logic [FLD_W-1:0] nx;
  logic [FLD_W-1:0] ny;
  logic [REC_W-1:0] seg;
  logic             unused_wh;

  always_comb begin
    nx = rec_x(new_head);
    ny = rec_y(new_head);
    fence_hit = (nx < AREA_X_LO) || (nx > HEAD_X_MAX) ||
                (ny < AREA_Y_LO) || (ny > HEAD_Y_MAX);
    self_hit = 1'b0;
    seg      = '0;
    // The tail vacates its cell this step unless the snake is growing.
    for (int i = 0; i < NSEG; i++) begin
      seg = body[(NSEG-1-i)*REC_W +: REC_W];
      if ((i < int'(len)) && (grow || (i != int'(len) - 1)) &&
          (rec_x(seg) == nx) && (rec_y(seg) == ny))
        self_hit = 1'b1;
    end
  end

  always_comb begin
    unused_wh = ^new_head[REC_W-1:H_LSB];
    for (int i = 0; i < NSEG; i++)
      unused_wh = unused_wh ^ (^body[i*REC_W+H_LSB +: 2*FLD_W]);
  end

endmodule

// File: rtl/snake_motion.sv
// Snake movement engine: direction latch, step divider, head/body shift,
// growth on food and game-over on fence or self collision.
module snake_motion #(
  parameter int STEP_DIV = 8,
  parameter int CELL     = snake_pkg::CELL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         start,
  input  logic [3:0]   dir_btn,
  input  logic [39:0]  food,
  output logic [39:0]  head,
  output logic [199:0] body,
  output logic         grow,
  output logic         endgame
);
  import snake_pkg::*;

  localparam logic [FLD_W-1:0] CELL10   = 10'(CELL);
  localparam logic [7:0]       CNT_LAST = 8'(STEP_DIV - 1);
  localparam logic [2:0]       LEN_MAX  = 3'(NSEG);
  localparam logic [REC_W-1:0] HEAD0    = {CELL10, CELL10, 10'd304, 10'd224};
  localparam logic [REC_W-1:0] SEG0_0   = {CELL10, CELL10, 10'd288, 10'd224};
  localparam logic [REC_W-1:0] SEG1_0   = {CELL10, CELL10, 10'd272, 10'd224};

  state_t           state_q, state_d;
  logic [REC_W-1:0] head_q;
  logic [REC_W-1:0] seg_q [NSEG];
  logic [2:0]       len_q;
  dir_t             dir_q, pend_q;
  logic [7:0]       cnt_q;
  logic             grow_q, end_q;

  logic             in_run, load_init, step, eat, hit;
  logic             fence_hit, self_hit;
  logic [FLD_W-1:0] hx, hy, nx, ny;
  logic [REC_W-1:0] new_head;
  logic [REC_W-1:0] seg_n [NSEG];
  logic [2:0]       len_n;
  logic [199:0]     body_q;
  dir_t             ref_dir, btn_dir;
  logic [3:0]       btn_ok;
  logic             btn_vld;
  logic             unused_food;

  assign in_run      = (state_q == ST_RUN);
  assign unused_food = ^food[REC_W-1:H_LSB];

  // Candidate move using the direction about to be adopted.
  always_comb begin
    step = in_run && tick && (cnt_q == CNT_LAST);
    hx   = rec_x(head_q);
    hy   = rec_y(head_q);
    nx   = hx;
    ny   = hy;
    case (pend_q)
      DIR_UP:   ny = hy + CELL10;
      DIR_DOWN: ny = hy - CELL10;
      DIR_LEFT: nx = hx - CELL10;
      default:  nx = hx + CELL10;
    endcase
    new_head = {CELL10, CELL10, nx, ny};
    eat      = (nx == rec_x(food)) && (ny == rec_y(food));
  end

  snake_collide u_collide (
    .new_head  (new_head),
    .body      (body_q),
    .len       (len_q),
    .grow      (eat),
    .fence_hit (fence_hit),
    .self_hit  (self_hit)
  );

  assign hit = fence_hit | self_hit;

  always_comb begin
    len_n    = (eat && (len_q < LEN_MAX)) ? len_q + 3'd1 : len_q;
    seg_n[0] = head_q;
    for (int i = 1; i < NSEG; i++)
      seg_n[i] = seg_q[i-1];
    for (int i = 0; i < NSEG; i++)
      if (i >= int'(len_n))
        seg_n[i] = '0;
  end

  // On a step cycle the reverse check is against the direction being adopted.
  always_comb begin
    ref_dir = step ? pend_q : dir_q;
    btn_ok  = dir_btn & ~dir_onehot(dir_reverse(ref_dir));
    btn_vld = |btn_ok;
    btn_dir = btn_ok[3] ? DIR_UP :
              btn_ok[2] ? DIR_DOWN :
              btn_ok[1] ? DIR_LEFT : DIR_RIGHT;
  end

  always_comb begin
    state_d   = state_q;
    load_init = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          load_init = 1'b1;
        end
      end
      ST_RUN: begin
        if (step && hit)
          state_d = ST_DEAD;
      end
      ST_DEAD: begin
        if (start) begin
          state_d   = ST_RUN;
          load_init = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset and (re)start share one initialisation path.
  always_ff @(posedge clk) begin
    if (rst || load_init) begin
      state_q  <= rst ? ST_IDLE : state_d;
      head_q   <= HEAD0;
      seg_q[0] <= SEG0_0;
      seg_q[1] <= SEG1_0;
      for (int i = 2; i < NSEG; i++)
        seg_q[i] <= '0;
      len_q    <= 3'd2;
      dir_q    <= DIR_RIGHT;
      pend_q   <= DIR_RIGHT;
      cnt_q    <= '0;
      grow_q   <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grow_q  <= 1'b0;
      if (in_run) begin
        if (tick)
          cnt_q <= step ? '0 : cnt_q + 8'd1;
        if (btn_vld)
          pend_q <= btn_dir;
        if (step) begin
          if (hit) begin
            end_q <= 1'b1;
          end else begin
            head_q <= new_head;
            for (int i = 0; i < NSEG; i++)
              seg_q[i] <= seg_n[i];
            len_q  <= len_n;
            dir_q  <= pend_q;
            grow_q <= eat;
          end
        end
      end
    end
  end

  always_comb begin
    body_q = '0;
    for (int i = 0; i < NSEG; i++)
      body_q[(NSEG-1-i)*REC_W +: REC_W] = seg_q[i];
  end

  assign head    = head_q;
  assign body    = body_q;
  assign grow    = grow_q;
  assign endgame = end_q;

endmodule
